// File: rtl/ram_arb_ctrl.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// It also provides a whole-RAM fill engine started by init_start.
module ram_arb_ctrl #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata,
    input  logic          init_start,
    input  logic [DW-1:0] init_value,
    output logic          busy,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_write,
    output logic          ram_select,
    input  logic [DW-1:0] ram_data_out
);

    // state | meaning
    // IDLE  | waiting; arbitrates requests, init_start has priority
    // ISSUE | RAM command for the granted access is on the bus
    // RESP  | done pulse; read data passes through from the RAM
    // INIT  | writing the fill value to every address in turn
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, INIT} state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state;
    logic          last_b;
    logic          acc_we;
    logic          pick_a;
    logic          pick_b;
    logic          idle_ok;
    logic [DW-1:0] rdata_q;

    always_comb begin
        idle_ok = rst_n && (state == IDLE) && !init_start;
        pick_a  = req_a && (!req_b || last_b);
        pick_b  = req_b && (!req_a || !last_b);
        gnt_a   = idle_ok && pick_a;
        gnt_b   = idle_ok && pick_b;
        done_a  = (state == RESP) && !last_b;
        done_b  = (state == RESP) && last_b;
        busy    = (state != IDLE);
        // Read data must be visible during the done cycle itself, then held.
        rdata   = ((state == RESP) && !acc_we) ? ram_data_out : rdata_q;
    end

    // The fill counter is ram_address itself; ram_data_in holds the fill value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            acc_we      <= 1'b0;
            rdata_q     <= '0;
            ram_select  <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_start) begin
                        state       <= INIT;
                        ram_select  <= 1'b1;
                        ram_write   <= 1'b1;
                        ram_address <= '0;
                        ram_data_in <= init_value;
                    end else if (req_a || req_b) begin
                        state       <= ISSUE;
                        last_b      <= !pick_a;
                        acc_we      <= pick_a ? we_a : we_b;
                        ram_select  <= 1'b1;
                        ram_write   <= pick_a ? we_a : we_b;
                        ram_address <= pick_a ? addr_a : addr_b;
                        ram_data_in <= pick_a ? wdata_a : wdata_b;
                    end
                end
                ISSUE: begin
                    state      <= RESP;
                    ram_select <= 1'b0;
                    ram_write  <= 1'b0;
                end
                RESP: begin
                    if (!acc_we) begin
                        rdata_q <= ram_data_out;
                    end
                    state <= IDLE;
                end
                INIT: begin
                    if (ram_address == LAST_ADDR) begin
                        state      <= IDLE;
                        ram_select <= 1'b0;
                        ram_write  <= 1'b0;
                    end else begin
                        ram_address <= ram_address + AW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ram_arb_ctrl.md
RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 SHALL have parameter AW, default 10, meaning RAM address width (1024 locations).
REQ-002 SHALL have parameter DW, default 8, meaning RAM data width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports req_a / req_b, input, 1 each, meaning the requester wants an access; held until its grant.
REQ-006 SHALL have ports we_a / we_b, input, 1 each, meaning 1 = write, 0 = read; sampled with the request.
REQ-007 SHALL have ports addr_a / addr_b, input, AW each, meaning the access address.
REQ-008 SHALL have ports wdata_a / wdata_b, input, DW each, meaning the write data.
REQ-009 SHALL have ports gnt_a / gnt_b, output, 1 each, meaning a one-cycle pulse: the request was accepted this cycle.
REQ-010 SHALL have ports done_a / done_b, output, 1 each, meaning a one-cycle pulse: the access completed.
REQ-011 SHALL have port rdata, output, DW, meaning read data, valid only while done_a or done_b is high for a read.
REQ-012 SHALL have port init_start, input, 1, meaning a pulse that starts a fill of the whole RAM.
REQ-013 SHALL have port init_value, input, DW, meaning the fill pattern, sampled with init_start.
REQ-014 SHALL have port busy, output, 1, meaning high whenever the FSM is not IDLE.
REQ-015 SHALL have ports ram_address (AW), ram_data_in (DW), ram_write (1) and ram_select (1), all outputs, meaning the RAM command; write and select are active-high.
REQ-016 SHALL have port ram_data_out, input, DW, meaning RAM read data, valid the cycle after a select-with-write-low cycle.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, RESP and INIT.
REQ-018 In IDLE with init_start=1, the block SHALL latch init_value, clear the fill counter to 0 and go to INIT; init_start SHALL take priority over all requests in that cycle.
REQ-019 In IDLE with any request and no init_start, the block SHALL pick a winner, pulse its gnt combinationally in that cycle, latch its we/addr/wdata and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin:
- a 1-bit last-winner register, reset value B, so A wins the first contention;
- under contention, the requester that did not win last time wins;
- a lone requester always wins.
REQ-021 In ISSUE, the block SHALL drive ram_select=1, ram_write=latched we, ram_address/ram_data_in=latched values, then go to RESP.
REQ-022 In RESP, the block SHALL:
- capture ram_data_out into rdata for a read (rdata holds its value otherwise);
- pulse done of the granted requester;
- return to IDLE.
REQ-023 Access latency SHALL be gnt at cycle N, RAM command at N+1, done/rdata at N+2; the earliest next gnt is at N+3.
REQ-024 In INIT, the block SHALL each cycle drive ram_select=1, ram_write=1, ram_address=counter, ram_data_in=latched value, then increment the counter; after address 2^AW-1 it SHALL return to IDLE (1024 write cycles, no counter wrap).
REQ-025 Outside ISSUE and INIT, ram_select and ram_write SHALL be 0.
REQ-026 No gnt SHALL be issued outside IDLE, and requests SHALL be held, not dropped.
REQ-027 init_start outside IDLE SHALL be ignored.
REQ-028 Requests with equal addresses SHALL still be serialized (no merging).

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously force: FSM to IDLE, last-winner to B, fill counter to 0, rdata to 0, gnt/done/busy to 0, ram_select/ram_write to 0, ram_address/ram_data_in to 0.
REQ-030 Reset asserted mid-access or mid-fill SHALL abort the operation with no done pulse, leaving partially written RAM contents as-is.
REQ-031 The block SHALL act on inputs from the first rising edge after rst_n deasserts.

Verification
REQ-032 Fill: init_start with init_value=0x5A -> busy for 1024 cycles, addresses 0..1023 written, then reads of A at 0, 511 and 1023 return 0x5A.
REQ-033 Single write then read: A writes 0xC3 @ 0x155 -> gnt_a@N, done_a@N+2; A then reads 0x155 -> rdata=0xC3 with done_a.
REQ-034 Contention: req_a and req_b held from reset -> grants alternate A, B, A, B, spaced 3 cycles, with no lost request.
REQ-035 Blocking: req_b asserted during a fill -> no gnt_b until the cycle after busy falls; an init_start issued during an access is ignored.
REQ-036 Reset mid-fill at counter=300 -> all outputs 0 immediately; a new init_start afterwards restarts at address 0.
